// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the 2-input gate sweep sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int IDX_W   = 2;
    localparam int TABLE_W = 4;

    localparam logic [TABLE_W-1:0] TT_AND2 = 4'b1000;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Settle counter: counts up while enabled, clears to zero, flags the last settle cycle.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives a shared 2-input gate through all four input vectors, captures its
// truth table and compares it against the expected table latched at start.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for start, drives 00
// S_SETTLE | holding the current vector while the gate settles
// S_SAMPLE | last hold cycle, gate_out captured at its end
// S_DONE   | one-cycle done pulse with pass valid
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [TABLE_W-1:0] exp_table,
    input  logic               gate_out,
    output logic               drv_a,
    output logic               drv_b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [TABLE_W-1:0] table_out
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_sweep_ctrl: SETTLE_CYCLES must be in 1..15");
    end
    if ((2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt_w
        $error("gate_sweep_ctrl: CNT_W too narrow for SETTLE_CYCLES");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TABLE_W-1:0] exp_q;
    logic [TABLE_W-1:0] table_nxt;
    logic               tc;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state != S_SETTLE),
        .en   (state == S_SETTLE),
        .tc   (tc)
    );

    // Table including the bit being captured this cycle, so pass lines up with done.
    always_comb begin
        table_nxt      = table_out;
        table_nxt[idx] = gate_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            exp_q     <= '0;
            drv_a     <= 1'b0;
            drv_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_q     <= exp_table;
                        table_out <= '0;
                        idx       <= '0;
                        pass      <= 1'b0;
                        drv_a     <= 1'b0;
                        drv_b     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        drv_a <= 1'b0;
                        drv_b <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tc) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        drv_a <= 1'b0;
                        drv_b <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        table_out <= table_nxt;
                        if (idx == '1) begin
                            done  <= 1'b1;
                            pass  <= (table_nxt == exp_q);
                            drv_a <= 1'b0;
                            drv_b <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            idx            <= idx + IDX_W'(1);
                            {drv_a, drv_b} <= idx + IDX_W'(1);
                            state          <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
